// File: rtl/pipe_reg_de_pkg.sv
// Shared types and defaults for the decode-to-execute pipeline register.
package pipe_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;
    localparam int unsigned NUM_DATA_DEFAULT   = 4;
    localparam int unsigned CTRL_WIDTH_DEFAULT = 12;

    // Control bundle handed from the control unit to execute
    typedef struct packed {
        logic [2:0] ALUctrl;
        logic       ALUSrc;
        logic       MemWrite;
        logic [1:0] ResultSrc;
        logic       PCSrc;
        logic       PcOp;
        logic       jalr;
        logic       RegWrite;
        logic       Branch;
    } ctrl_t;

    // Bubble: no memory write, no register write, no redirect
    localparam ctrl_t CTRL_NOP_DEFAULT = '0;

    // Word positions inside the data payload (word 0 in the LSBs)
    localparam int unsigned RD1 = 0;
    localparam int unsigned RD2 = 1;
    localparam int unsigned IMM = 2;
    localparam int unsigned PC  = 3;

endpackage

// File: rtl/pipe_reg_de_if.sv
// Handshake bundle between decode, the D/E register and execute.
interface pipe_reg_de_if
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_WIDTH = CTRL_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned NUM_DATA   = NUM_DATA_DEFAULT
) ();

    logic                           flush;
    logic                           in_valid;
    logic                           in_ready;
    logic [CTRL_WIDTH-1:0]          in_ctrl;
    logic [NUM_DATA*DATA_WIDTH-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [CTRL_WIDTH-1:0]          out_ctrl;
    logic [NUM_DATA*DATA_WIDTH-1:0] out_data;
    logic [1:0]                     occupancy;

    // Surrounding pipeline (decode producer + execute consumer)
    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    // The pipeline register itself
    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );

endinterface

// File: rtl/pipe_reg_de_slot.sv
// One storage entry (valid + ctrl + data) with load, clear-to-NOP and hold.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned           CTRL_WIDTH = CTRL_WIDTH_DEFAULT,
    parameter int unsigned           DATA_BITS  = NUM_DATA_DEFAULT * DATA_WIDTH_DEFAULT,
    parameter logic [CTRL_WIDTH-1:0] CTRL_NOP   = CTRL_WIDTH'(CTRL_NOP_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic [CTRL_WIDTH-1:0] ldCtrl,
    input  logic [DATA_BITS-1:0]  ldData,
    output logic                  valid,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [DATA_BITS-1:0]  data
);

    // Reset wipes data; clear only invalidates and forces the bubble control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= CTRL_NOP;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_NOP;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ldCtrl;
            data  <= ldData;
        end
    end

endmodule

// File: rtl/pipe_reg_de.sv
// Decode-to-execute pipeline register: main slot drives execute, skid slot
// absorbs the one entry accepted while execute stalls.
module pipe_reg_de
    import pipe_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned           NUM_DATA   = NUM_DATA_DEFAULT,
    parameter int unsigned           CTRL_WIDTH = CTRL_WIDTH_DEFAULT,
    parameter logic [CTRL_WIDTH-1:0] CTRL_NOP   = CTRL_WIDTH'(CTRL_NOP_DEFAULT)
) (
    input logic         clk,
    input logic         rst_n,
    pipe_reg_de_if.slave bus
);

    localparam int unsigned DATA_BITS = NUM_DATA * DATA_WIDTH;

    logic                  mainValid, skidValid;
    logic [CTRL_WIDTH-1:0] mainCtrl, skidCtrl, mainLdCtrl;
    logic [DATA_BITS-1:0]  mainData, skidData, mainLdData;
    logic                  mainLoad, mainClear, mainFromSkid;
    logic                  skidLoad, skidClear;
    logic                  mainValidNext, skidValidNext;
    logic                  inXfer, outXfer;
    logic                  inReadyQ;
    logic [1:0]            occupancyQ;

    // Slot control: flush first, then refill a free main, else park in skid
    always_comb begin
        mainLoad     = 1'b0;
        mainClear    = 1'b0;
        mainFromSkid = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;
        inXfer       = bus.in_valid && inReadyQ;
        outXfer      = mainValid && bus.out_ready;

        if (bus.flush) begin
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else if (!mainValid || outXfer) begin
            if (skidValid) begin
                mainLoad     = 1'b1;
                mainFromSkid = 1'b1;
                if (inXfer) begin
                    skidLoad = 1'b1;
                end else begin
                    skidClear = 1'b1;
                end
            end else if (inXfer) begin
                mainLoad = 1'b1;
            end else begin
                mainClear = 1'b1;
            end
        end else if (inXfer) begin
            skidLoad = 1'b1;
        end

        mainLdCtrl    = mainFromSkid ? skidCtrl : bus.in_ctrl;
        mainLdData    = mainFromSkid ? skidData : bus.in_data;
        mainValidNext = mainClear ? 1'b0 : (mainLoad ? 1'b1 : mainValid);
        skidValidNext = skidClear ? 1'b0 : (skidLoad ? 1'b1 : skidValid);
    end

    pipe_slot #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_BITS  (DATA_BITS),
        .CTRL_NOP   (CTRL_NOP)
    ) mainSlot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mainLoad),
        .clear  (mainClear),
        .ldCtrl (mainLdCtrl),
        .ldData (mainLdData),
        .valid  (mainValid),
        .ctrl   (mainCtrl),
        .data   (mainData)
    );

    pipe_slot #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_BITS  (DATA_BITS),
        .CTRL_NOP   (CTRL_NOP)
    ) skidSlot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skidLoad),
        .clear  (skidClear),
        .ldCtrl (bus.in_ctrl),
        .ldData (bus.in_data),
        .valid  (skidValid),
        .ctrl   (skidCtrl),
        .data   (skidData)
    );

    // Registered ready and fill level, tracking next-cycle slot state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inReadyQ   <= 1'b1;
            occupancyQ <= 2'd0;
        end else begin
            inReadyQ   <= !skidValidNext;
            occupancyQ <= 2'(mainValidNext) + 2'(skidValidNext);
        end
    end

    assign bus.in_ready  = inReadyQ;
    assign bus.occupancy = occupancyQ;
    assign bus.out_valid = mainValid;
    assign bus.out_ctrl  = mainCtrl;
    assign bus.out_data  = mainData;

    // Two slots can never report three entries
    occupancyBound: assert property (@(posedge clk) disable iff (!rst_n) occupancyQ != 2'd3);

endmodule

// File: tb/tb_pipe_reg_de.sv
// Directed and scoreboarded checks for the decode-to-execute register.
module tb_pipe_reg_de;
    import pipe_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned ND = 4;
    localparam int unsigned CW = 12;
    localparam int unsigned DB = ND * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pipe_reg_de_if #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .NUM_DATA(ND)) bus ();

    pipe_reg_de #(
        .DATA_WIDTH (DW),
        .NUM_DATA   (ND),
        .CTRL_WIDTH (CW),
        .CTRL_NOP   (CW'(0))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int assertCnt = 0;
    int failCnt   = 0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DB-1:0] d;
    } entry_t;
    entry_t sb[$];

    task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
        assertCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DB-1:0] d);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_data  = d;
    endtask

    function automatic logic [DB-1:0] mkData(input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                                             input logic [DW-1:0] im, input logic [DW-1:0] pc);
        logic [DB-1:0] d;
        d = '0;
        d[RD1*DW +: DW] = r1;
        d[RD2*DW +: DW] = r2;
        d[IMM*DW +: DW] = im;
        d[PC*DW  +: DW] = pc;
        return d;
    endfunction

    task automatic checkOut(input string tag, input logic v, input logic [CW-1:0] c,
                            input logic [DB-1:0] d, input logic [1:0] occ, input logic rdy);
        check({tag, "_valid"}, DB'(bus.out_valid), DB'(v));
        check({tag, "_ctrl"},  DB'(bus.out_ctrl),  DB'(c));
        check({tag, "_data"},  bus.out_data, d);
        check({tag, "_occ"},   DB'(bus.occupancy), DB'(occ));
        check({tag, "_ready"}, DB'(bus.in_ready),  DB'(rdy));
    endtask

    initial begin
        logic [DB-1:0] dA, dB, dC, dD, dE, dF, dG, dH, dS;
        logic          iv, ordy;
        entry_t        e;

        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0);

        // Reset then a back-to-back stream
        rst_n = 1'b0;
        tick();
        tick();
        checkOut("reset", 1'b0, '0, '0, 2'd0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dS = mkData(32'h11 + DW'(i), 32'h100 + DW'(i), 32'h0, 32'h400 + DW'(4 * i));
            drive(1'b1, CW'(12'h0A5), dS);
            tick();
            checkOut($sformatf("stream%0d", i), 1'b1, CW'(12'h0A5), dS, 2'd1, 1'b1);
        end
        drive(1'b0, '0, '0);
        tick();
        checkOut("stream_end", 1'b0, '0, mkData(32'h14, 32'h103, 32'h0, 32'h40C), 2'd0, 1'b1);

        // Stall fill then drain
        dA = mkData(32'h1, 32'h0, 32'h0, 32'h0);
        dB = mkData(32'h2, 32'h0, 32'h0, 32'h0);
        bus.out_ready = 1'b0;
        drive(1'b1, CW'(12'h111), dA);
        tick();
        checkOut("fillA", 1'b1, CW'(12'h111), dA, 2'd1, 1'b1);
        drive(1'b1, CW'(12'h222), dB);
        tick();
        checkOut("fillB", 1'b1, CW'(12'h111), dA, 2'd2, 1'b0);
        drive(1'b0, '0, '0);
        tick();
        checkOut("holdA", 1'b1, CW'(12'h111), dA, 2'd2, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        checkOut("drainA", 1'b1, CW'(12'h222), dB, 2'd1, 1'b1);
        tick();
        checkOut("drainB", 1'b0, '0, dB, 2'd0, 1'b1);

        // Flush while full, with a same-cycle input
        dA = mkData(32'hA2, 32'h1, 32'h2, 32'h3);
        dB = mkData(32'hB2, 32'h4, 32'h5, 32'h6);
        dC = mkData(32'hC0, 32'h7, 32'h8, 32'h9);
        bus.out_ready = 1'b0;
        drive(1'b1, CW'(12'h0F1), dA);
        tick();
        drive(1'b1, CW'(12'h0F2), dB);
        tick();
        checkOut("preflush", 1'b1, CW'(12'h0F1), dA, 2'd2, 1'b0);
        bus.flush = 1'b1;
        drive(1'b1, CW'(12'hFFF), dC);
        tick();
        checkOut("flush", 1'b0, '0, dA, 2'd0, 1'b1);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0);
        tick();
        checkOut("postflush", 1'b0, '0, dA, 2'd0, 1'b1);

        // Simultaneous input and output at occupancy 1
        dD = mkData(32'hD, 32'hD1, 32'hD2, 32'hD3);
        dE = mkData(32'hE, 32'hE1, 32'hE2, 32'hE3);
        drive(1'b1, CW'(12'h3C1), dD);
        tick();
        checkOut("simD", 1'b1, CW'(12'h3C1), dD, 2'd1, 1'b1);
        drive(1'b1, CW'(12'h3C2), dE);
        tick();
        checkOut("simE", 1'b1, CW'(12'h3C2), dE, 2'd1, 1'b1);
        drive(1'b0, '0, '0);
        tick();
        checkOut("simEnd", 1'b0, '0, dE, 2'd0, 1'b1);

        // Reset mid-stall, then one entry through
        dG = mkData(32'h6, 32'h0, 32'h0, 32'h1);
        dH = mkData(32'h7, 32'h0, 32'h0, 32'h2);
        dF = mkData(32'hF, 32'hF1, 32'hF2, 32'hF3);
        bus.out_ready = 1'b0;
        drive(1'b1, CW'(12'h0A1), dG);
        tick();
        drive(1'b1, CW'(12'h0A2), dH);
        tick();
        checkOut("prerst", 1'b1, CW'(12'h0A1), dG, 2'd2, 1'b0);
        drive(1'b0, '0, '0);
        rst_n = 1'b0;
        tick();
        checkOut("midrst", 1'b0, '0, '0, 2'd0, 1'b1);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, CW'(12'h5A5), dF);
        tick();
        checkOut("postrstF", 1'b1, CW'(12'h5A5), dF, 2'd1, 1'b1);
        drive(1'b0, '0, '0);
        tick();
        checkOut("postrstEnd", 1'b0, '0, dF, 2'd0, 1'b1);

        // Random valid/ready against a reference queue
        for (int cyc = 0; cyc < 10000; cyc++) begin
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            bus.out_ready = ordy;
            drive(iv, CW'($urandom), {$urandom, $urandom, $urandom, $urandom});
            if (bus.out_valid && ordy && sb.size() != 0) begin
                check("rnd_ctrl", DB'(bus.out_ctrl), DB'(sb[0].c));
                check("rnd_data", bus.out_data, sb[0].d);
                void'(sb.pop_front());
            end
            if (iv && bus.in_ready) begin
                e.c = bus.in_ctrl;
                e.d = bus.in_data;
                sb.push_back(e);
            end
            tick();
            check("rnd_occ",   DB'(bus.occupancy), DB'(sb.size()));
            check("rnd_valid", DB'(bus.out_valid), DB'(sb.size() != 0));
            check("rnd_ready", DB'(bus.in_ready),  DB'(sb.size() < 2));
            if (!bus.out_valid) begin
                check("rnd_nop", DB'(bus.out_ctrl), '0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
